// File: rtl/telem_ft_packer_pkg.sv
// telem_ft_pkg: shared widths, frame length, FSM state type and CRC helper
// for the telemetry-to-FT-bridge packer.
// Build option: TELEM_FT_PACKER_CRC_EN appends a CRC-16-CCITT word to each frame.
package telem_ft_pkg;

    localparam int unsigned PKT_W   = 88;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned SEQ_W   = 8;
    localparam int unsigned ENTRY_W = PKT_W + SEQ_W;

    localparam logic [WORD_W-1:0] SYNC_WORD_DEF = 16'hA55A;

`ifdef TELEM_FT_PACKER_CRC_EN
    localparam int unsigned FRAME_WORDS = 8;
`else
    localparam int unsigned FRAME_WORDS = 7;
`endif

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    // CRC-16-CCITT update over one 16-bit word, MSB first, no reflection.
    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in,
                                               input logic [15:0] data);
        logic [15:0] c;
        logic [15:0] d;
        logic        fb;
        c = crc_in;
        d = data;
        for (int unsigned i = 0; i < 16; i++) begin
            fb = c[15] ^ d[15];
            c  = {c[14:0], 1'b0};
            if (fb) begin
                c = c ^ CRC_POLY;
            end
            d = {d[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/telem_ft_packer_if.sv
// FT bridge user-side transmit port: 16-bit word, byte enables, valid and
// the bridge's full back-pressure flag.
interface telem_ft_packer_if;
    import telem_ft_pkg::*;

    logic [WORD_W-1:0] ui_din;
    logic [1:0]        ui_din_be;
    logic              ui_din_valid;
    logic              ui_din_full;

    // master: the packer driving words; slave: the FT bridge receiving them
    modport master (output ui_din, output ui_din_be, output ui_din_valid, input ui_din_full);
    modport slave  (input ui_din, input ui_din_be, input ui_din_valid, output ui_din_full);

endinterface

// File: rtl/telem_ft_packer_fifo.sv
// telem_pkt_fifo: single-clock packet FIFO holding {seq, packet} entries.
// Read data is the current head (show-ahead); a push into a full FIFO is
// taken only when a pop happens in the same cycle.
module telem_pkt_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 96
) (
    input  logic                     clk_128M,
    input  logic                     rst_128M,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage array: written on accepted pushes, no reset needed
    always_ff @(posedge clk_128M) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; reset discards all buffered entries
    always_ff @(posedge clk_128M or posedge rst_128M) begin
        if (rst_128M) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/telem_ft_packer.sv
// telem_ft_packer: buffers 88-bit telemetry packets and frames each one as
// SYNC_WORD followed by 16-bit data words on the FT bridge transmit port.
// Build option: TELEM_FT_PACKER_CRC_EN adds an 8th word carrying
// CRC-16-CCITT over the data words W1..W6.
module telem_ft_packer
    import telem_ft_pkg::*;
#(
    parameter int unsigned       PKT_FIFO_DEPTH = 4,
    parameter logic [WORD_W-1:0] SYNC_WORD      = SYNC_WORD_DEF,
    parameter int unsigned       DROP_CNT_W     = 16
) (
    input  logic                  clk_128M,
    input  logic                  rst_128M,
    input  logic [PKT_W-1:0]      packet_data,
    input  logic                  packet_valid,
    telem_ft_packer_if.master     ft,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic [SEQ_W-1:0]      seq_num,
    output logic                  busy
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_WORDS - 1);

    state_t                          state, state_nxt;
    logic [2:0]                      idx, idx_nxt;
    logic [ENTRY_W-1:0]              frame_q;
    logic [ENTRY_W-1:0]              fifo_rd;
    logic                            fifo_full;
    logic                            fifo_empty;
    logic [$clog2(PKT_FIFO_DEPTH):0] fifo_count;
    logic                            pop;
    logic                            accept;
    logic                            drop;
    logic                            xfer;
    logic [WORD_W-1:0]               word;

    assign accept = packet_valid && (!fifo_full || pop);
    assign drop   = packet_valid && fifo_full && !pop;
    assign xfer   = ft.ui_din_valid && !ft.ui_din_full;

    telem_pkt_fifo #(
        .DEPTH (PKT_FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_128M (clk_128M),
        .rst_128M (rst_128M),
        .push     (accept),
        .wr_data  ({seq_num, packet_data}),
        .pop      (pop),
        .rd_data  (fifo_rd),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Sequence numbering of accepted packets and saturating drop count
    always_ff @(posedge clk_128M or posedge rst_128M) begin
        if (rst_128M) begin
            seq_num    <= '0;
            drop_count <= '0;
        end else begin
            if (accept) begin
                seq_num <= seq_num + 1'b1;
            end
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    // Framing state, word index and the frame register loaded on each pop
    always_ff @(posedge clk_128M or posedge rst_128M) begin
        if (rst_128M) begin
            state   <= ST_IDLE;
            idx     <= '0;
            frame_q <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (pop) begin
                frame_q <= fifo_rd;
            end
        end
    end

    // Next state: the last-word transfer pops the next packet directly and
    // stays in SEND at W0, so back-to-back frames have no gap cycle.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_SEND;
                    idx_nxt   = '0;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    if (idx == LAST_IDX) begin
                        idx_nxt = '0;
                        if (!fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

`ifdef TELEM_FT_PACKER_CRC_EN
    logic [15:0] crc_q;

    // Running CRC over W1..W6, folded in as each word transfers
    always_ff @(posedge clk_128M or posedge rst_128M) begin
        if (rst_128M) begin
            crc_q <= CRC_INIT;
        end else if (pop) begin
            crc_q <= CRC_INIT;
        end else if (xfer && (idx != 3'd0) && (idx != LAST_IDX)) begin
            crc_q <= crc16_word(crc_q, word);
        end
    end
`endif

    // Word selection for the current frame position
    always_comb begin
        word = '0;
        if (state == ST_SEND) begin
            case (idx)
                3'd0:    word = SYNC_WORD;
                3'd1:    word = frame_q[15:0];
                3'd2:    word = frame_q[31:16];
                3'd3:    word = frame_q[47:32];
                3'd4:    word = frame_q[63:48];
                3'd5:    word = frame_q[79:64];
                3'd6:    word = frame_q[95:80];
`ifdef TELEM_FT_PACKER_CRC_EN
                3'd7:    word = crc_q;
`endif
                default: word = '0;
            endcase
        end
    end

    assign ft.ui_din       = word;
    assign ft.ui_din_be    = 2'b11;
    assign ft.ui_din_valid = (state == ST_SEND);
    assign busy            = (fifo_count != '0) || (state != ST_IDLE);

endmodule

// File: tb/tb_telem_ft_packer.sv
// Directed bench for telem_ft_packer: expected frame words are queued when
// packets are driven and compared as the bridge port transfers them.
module tb_telem_ft_packer;
    import telem_ft_pkg::*;

    logic        clk_128M = 1'b0;
    logic        rst_128M;
    logic [87:0] packet_data;
    logic        packet_valid;
    logic [15:0] drop_count;
    logic [7:0]  seq_num;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  model_seq;
    logic        stalled;
    logic [15:0] stall_word;
    logic        gap_watch;
    int          gap_cnt;

    localparam logic [87:0] PKT_A = 88'h0B_AAAA_9999_8888_7777_6666;
    localparam logic [87:0] PKT_B = 88'h1F_5555_4444_3333_2222_1111;

    telem_ft_packer_if ui ();

    telem_ft_packer #(
        .PKT_FIFO_DEPTH (4),
        .SYNC_WORD      (16'hA55A),
        .DROP_CNT_W     (16)
    ) dut (
        .clk_128M     (clk_128M),
        .rst_128M     (rst_128M),
        .packet_data  (packet_data),
        .packet_valid (packet_valid),
        .ft           (ui),
        .drop_count   (drop_count),
        .seq_num      (seq_num),
        .busy         (busy)
    );

    always #4 clk_128M = ~clk_128M;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Independent bit-serial CRC-16-CCITT over a whole message
    function automatic logic [15:0] crc_ref(input logic [95:0] msg);
        logic [15:0] c;
        logic        top;
        c = 16'hFFFF;
        for (int i = 95; i >= 0; i--) begin
            top = c[15] ^ msg[i];
            c   = c << 1;
            if (top) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic push_frame(input logic [7:0] s, input logic [87:0] d);
        logic [15:0] w [6];
        w[0] = d[15:0];
        w[1] = d[31:16];
        w[2] = d[47:32];
        w[3] = d[63:48];
        w[4] = d[79:64];
        w[5] = {s, d[87:80]};
        exp_q.push_back(16'hA55A);
        for (int i = 0; i < 6; i++) exp_q.push_back(w[i]);
        if (FRAME_WORDS == 8) exp_q.push_back(crc_ref({w[0], w[1], w[2], w[3], w[4], w[5]}));
    endtask

    // Called at posedge+1; drives a one-cycle strobe and returns at next posedge+1
    task automatic send(input logic [87:0] d, input bit accept);
        packet_data  = d;
        packet_valid = 1'b1;
        if (accept) begin
            push_frame(model_seq, d);
            model_seq = model_seq + 8'd1;
        end
        @(posedge clk_128M);
        #1;
        packet_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(posedge clk_128M);
            #1;
            n++;
        end
        check("drain_done", {95'b0, (exp_q.size() == 0 && !busy)}, 96'd1);
    endtask

    // Bridge-side monitor: stability while stalled, scoreboard on transfers
    always @(negedge clk_128M) begin
        if (rst_128M) begin
            stalled = 1'b0;
        end else begin
            if (gap_watch && !ui.ui_din_valid) gap_cnt++;
            if (stalled) begin
                check("stall_valid", {95'b0, ui.ui_din_valid}, 96'd1);
                check("stall_word", {80'b0, ui.ui_din}, {80'b0, stall_word});
            end
            stalled = ui.ui_din_valid && ui.ui_din_full;
            stall_word = ui.ui_din;
            if (ui.ui_din_valid && !ui.ui_din_full) begin
                check("word_expected", {95'b0, (exp_q.size() != 0)}, 96'd1);
                check("byte_en", {94'b0, ui.ui_din_be}, 96'd3);
                if (exp_q.size() != 0) begin
                    check("word", {80'b0, ui.ui_din}, {80'b0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_128M         = 1'b1;
        packet_data      = '0;
        packet_valid     = 1'b0;
        ui.ui_din_full   = 1'b0;
        model_seq        = 8'd0;
        stalled          = 1'b0;
        stall_word       = '0;
        gap_watch        = 1'b0;
        gap_cnt          = 0;

        #3;
        check("rst_din", {80'b0, ui.ui_din}, 96'h0);
        check("rst_valid", {95'b0, ui.ui_din_valid}, 96'h0);
        check("rst_be", {94'b0, ui.ui_din_be}, 96'h3);
        check("rst_drop", {80'b0, drop_count}, 96'h0);
        check("rst_seq", {88'b0, seq_num}, 96'h0);
        check("rst_busy", {95'b0, busy}, 96'h0);
        repeat (2) @(posedge clk_128M);
        #1 rst_128M = 1'b0;

        // Single packet and first-word latency
        @(posedge clk_128M);
        #1;
        send(PKT_A, 1'b1);
        @(negedge clk_128M);
        check("lat_n1_valid", {95'b0, ui.ui_din_valid}, 96'd0);
        @(posedge clk_128M);
        @(negedge clk_128M);
        check("lat_n2_valid", {95'b0, ui.ui_din_valid}, 96'd1);
        check("lat_n2_sync", {80'b0, ui.ui_din}, 96'hA55A);
        @(posedge clk_128M);
        #1;
        drain();
        check("seq_after_1", {88'b0, seq_num}, 96'd1);

        // Back-pressure held for 5 cycles while W3 is presented
        send(PKT_A, 1'b1);
        repeat (4) @(posedge clk_128M);
        #1 ui.ui_din_full = 1'b1;
        #2;
        check("hold_w3", {80'b0, ui.ui_din}, 96'h8888);
        check("hold_valid", {95'b0, ui.ui_din_valid}, 96'd1);
        repeat (5) @(posedge clk_128M);
        #1 ui.ui_din_full = 1'b0;
        drain();
        check("seq_after_2", {88'b0, seq_num}, 96'd2);

        // Overflow: first packet goes straight to the frame register and
        // stalls at W0, four more fill the FIFO, the last two are dropped.
        @(posedge clk_128M);
        #1 rst_128M = 1'b1;
        exp_q.delete();
        model_seq = 8'd0;
        @(posedge clk_128M);
        #1 rst_128M = 1'b0;
        ui.ui_din_full = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(PKT_B ^ 88'(i), (i < 5));
        end
        check("ovf_drop", {80'b0, drop_count}, 96'd2);
        check("ovf_seq", {88'b0, seq_num}, 96'd5);
        check("ovf_busy", {95'b0, busy}, 96'd1);
        check("ovf_w0", {80'b0, ui.ui_din}, 96'hA55A);
        repeat (3) @(posedge clk_128M);
        #1 ui.ui_din_full = 1'b0;
        drain();
        check("ovf_drop_kept", {80'b0, drop_count}, 96'd2);

        // 300 packets, one per frame period: contiguous frames, seq wraps
        send(PKT_A ^ 88'h5A, 1'b1);
        for (int k = 1; k < 300; k++) begin
            repeat (FRAME_WORDS - 1) @(posedge clk_128M);
            #1;
            gap_watch = 1'b1;
            send(PKT_A ^ 88'(k * 7919), 1'b1);
        end
        repeat (FRAME_WORDS - 1) @(posedge clk_128M);
        #1 gap_watch = 1'b0;
        check("stream_gaps", 96'(gap_cnt), 96'd0);
        drain();
        check("stream_drop", {80'b0, drop_count}, 96'd2);
        check("stream_seq", {88'b0, seq_num}, 96'(8'(5 + 300)));

        // Asynchronous reset while W4 is on the port
        send(PKT_B, 1'b1);
        repeat (5) @(posedge clk_128M);
        #1;
        check("pre_rst_w4", {80'b0, ui.ui_din}, 96'h4444);
        #1 rst_128M = 1'b1;
        #1;
        check("arst_valid", {95'b0, ui.ui_din_valid}, 96'd0);
        check("arst_din", {80'b0, ui.ui_din}, 96'h0);
        check("arst_busy", {95'b0, busy}, 96'd0);
        check("arst_seq", {88'b0, seq_num}, 96'd0);
        check("arst_drop", {80'b0, drop_count}, 96'd0);
        exp_q.delete();
        model_seq = 8'd0;
        @(posedge clk_128M);
        #1 rst_128M = 1'b0;
        @(posedge clk_128M);
        #1;
        send(PKT_A, 1'b1);
        drain();
        check("post_rst_seq", {88'b0, seq_num}, 96'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
